// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch front end for an SPI-backed
// instruction memory. It issues one word read at a time to the SPI read
// stage, converts the returned big-first byte stream into an RV32
// little-endian word, and holds it for the consumer until it is accepted.
//
// Optional feature: define IFETCH_PREFETCH_EN to add a one-entry prefetch
// buffer. While an instruction is being held, the buffer fetches the next
// sequential word so that back-to-back handshakes keep instr_valid high.
// With the macro undefined, the block fetches strictly one word at a time.
module instr_fetch #(
    parameter logic [23:0] RESET_PC = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_pc_load,
    input  logic [23:0] i_pc_load_addr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr_data,
    output logic [23:0] o_instr_pc,
    output logic        o_mem_start,
    output logic [23:0] o_mem_addr,
    input  logic        i_mem_done,
    input  logic [31:0] i_mem_data
);

    // Fetch addresses are always word aligned, including the reset vector.
    localparam logic [23:0] PC_MASK    = 24'hFFFFFC;
    localparam logic [23:0] RESET_PC_A = RESET_PC & PC_MASK;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [23:0] r_fetch_pc;
    logic [31:0] r_instr_data;
    logic [23:0] r_instr_pc;

    logic        w_handshake;
    logic [23:0] w_load_pc;
    logic [23:0] w_seq_pc;

`ifdef IFETCH_PREFETCH_EN
    logic        r_pf_valid;
    logic        r_pf_busy;
    logic [31:0] r_pf_data;
    logic [23:0] r_pf_pc;
    logic        w_pf_done;
    logic        w_pf_fill;
`endif

    // The SPI stage delivers the lowest-address byte first in [31:24];
    // RV32 expects that byte in [7:0], so the four bytes are reversed.
    function automatic logic [31:0] f_spi_to_le(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign w_handshake = o_instr_valid & i_instr_ready;
    // Masking keeps the low address bits of the redirect target out of the PC.
    assign w_load_pc   = i_pc_load_addr & PC_MASK;
    // 24-bit add wraps 0xFFFFFC to 0x000000 on its own.
    assign w_seq_pc    = r_instr_pc + 24'd4;

    assign o_instr_data = r_instr_data;
    assign o_instr_pc   = r_instr_pc;
    assign o_mem_addr   = r_fetch_pc;

`ifdef IFETCH_PREFETCH_EN
    assign w_pf_done = r_pf_busy & i_mem_done;
    // Buffer captures a prefetch result only when the held instruction is not
    // being consumed in the same cycle (otherwise the result goes straight out).
    assign w_pf_fill = rst_n & ~i_pc_load & (r_state == S_HOLD) &
                       ~w_handshake & w_pf_done;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect always wins and forces one idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (i_mem_done) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_handshake) begin
`ifdef IFETCH_PREFETCH_EN
                    // Stay valid when a successor word is already available.
                    if (!(r_pf_valid || w_pf_done)) begin
                        w_state_nxt = S_REQ;
                    end
`else
                    w_state_nxt = S_REQ;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_pc_load) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Outputs decoded from the current state only.
    always_comb begin
        o_instr_valid = 1'b0;
        o_mem_start   = 1'b0;
        case (r_state)
            S_REQ: begin
                o_mem_start = 1'b1;
            end
            S_HOLD: begin
                o_instr_valid = 1'b1;
`ifdef IFETCH_PREFETCH_EN
                o_mem_start   = r_pf_busy;
`endif
            end
            default: begin
                o_instr_valid = 1'b0;
                o_mem_start   = 1'b0;
            end
        endcase
    end

    // Fetch PC, held instruction and prefetch bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_data <= 32'h0;
            r_instr_pc   <= RESET_PC_A;
            r_fetch_pc   <= RESET_PC_A;
`ifdef IFETCH_PREFETCH_EN
            r_pf_valid   <= 1'b0;
            r_pf_busy    <= 1'b0;
`endif
        end else if (i_pc_load) begin
            // Any read in flight is abandoned; its result is never captured.
            r_fetch_pc <= w_load_pc;
`ifdef IFETCH_PREFETCH_EN
            r_pf_valid <= 1'b0;
            r_pf_busy  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_mem_done) begin
                        r_instr_data <= f_spi_to_le(i_mem_data);
                        r_instr_pc   <= r_fetch_pc;
                    end
                end
                S_HOLD: begin
`ifdef IFETCH_PREFETCH_EN
                    if (w_handshake) begin
                        if (r_pf_valid) begin
                            r_instr_data <= r_pf_data;
                            r_instr_pc   <= r_pf_pc;
                            r_pf_valid   <= 1'b0;
                        end else if (w_pf_done) begin
                            r_instr_data <= f_spi_to_le(i_mem_data);
                            r_instr_pc   <= r_fetch_pc;
                            r_pf_busy    <= 1'b0;
                        end else if (r_pf_busy) begin
                            // The in-flight prefetch becomes the demand fetch;
                            // r_fetch_pc already points at it, so the request
                            // stays asserted with a stable address.
                            r_pf_busy <= 1'b0;
                        end else begin
                            r_fetch_pc <= w_seq_pc;
                        end
                    end else if (r_pf_busy) begin
                        if (i_mem_done) begin
                            r_pf_valid <= 1'b1;
                            r_pf_busy  <= 1'b0;
                        end
                    end else if (!r_pf_valid) begin
                        // Issued from a registered flag, so the request is
                        // always low in the cycle right after a completion.
                        r_pf_busy  <= 1'b1;
                        r_fetch_pc <= w_seq_pc;
                    end
`else
                    if (w_handshake) begin
                        r_fetch_pc <= w_seq_pc;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IFETCH_PREFETCH_EN
    // Prefetch buffer payload; validity is tracked by r_pf_valid.
    always_ff @(posedge clk) begin
        if (w_pf_fill) begin
            r_pf_data <= f_spi_to_le(i_mem_data);
            r_pf_pc   <= r_fetch_pc;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch (default build, no prefetch buffer). A byte-level
// memory image feeds the SPI-side port; a transaction-level model predicts
// which instruction is held, whether a read is being requested, and from
// which address, and is compared against the DUT on every falling edge.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_pc_load;
    logic [23:0] i_pc_load_addr;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr_data;
    logic [23:0] o_instr_pc;
    logic        o_mem_start;
    logic [23:0] o_mem_addr;
    logic        i_mem_done;
    logic [31:0] i_mem_data;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model: one idle cycle after reset/redirect, then a read is requested
    // until it completes; the word is then held until accepted.
    bit          m_quiet = 1'b1;
    bit          m_valid = 1'b0;
    logic [31:0] m_data  = 32'h0;
    logic [23:0] m_pc    = 24'h0;
    logic [23:0] m_fetch = 24'h0;

    instr_fetch #(.RESET_PC(24'h000000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pc_load      (i_pc_load),
        .i_pc_load_addr (i_pc_load_addr),
        .o_instr_valid  (o_instr_valid),
        .i_instr_ready  (i_instr_ready),
        .o_instr_data   (o_instr_data),
        .o_instr_pc     (o_instr_pc),
        .o_mem_start    (o_mem_start),
        .o_mem_addr     (o_mem_addr),
        .i_mem_done     (i_mem_done),
        .i_mem_data     (i_mem_data)
    );

    always #5 clk = ~clk;

    // Memory image: word 0 holds 0x00000013 (addi x0,x0,0); elsewhere a
    // position-dependent pattern so every byte lane is distinguishable.
    function automatic logic [7:0] mbyte(input logic [23:0] a);
        logic [7:0] b;
        if (a[23:2] == 22'd0) b = (a[1:0] == 2'b00) ? 8'h13 : 8'h00;
        else                  b = a[7:0] ^ (a[15:8] + 8'h5C) ^ {a[19:16], a[23:20]};
        return b;
    endfunction

    // Word as streamed by the SPI stage: lowest address first, in [31:24].
    function automatic logic [31:0] word_spi(input logic [23:0] a);
        return {mbyte(a), mbyte(a + 24'd1), mbyte(a + 24'd2), mbyte(a + 24'd3)};
    endfunction

    // Word as an RV32 core sees it: lowest address in [7:0].
    function automatic logic [31:0] word_le(input logic [23:0] a);
        return {mbyte(a + 24'd3), mbyte(a + 24'd2), mbyte(a + 24'd1), mbyte(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Wait for a request, let it run lat extra cycles, then complete it.
    task automatic serve(input int lat);
        int n = 0;
        while (!o_mem_start && n < 20) begin step(); n++; end
        chk("mem_start_seen", {31'd0, o_mem_start}, 32'd1);
        repeat (lat) step();
        i_mem_done = 1'b1;
        i_mem_data = word_spi(o_mem_addr);
        step();
        i_mem_done = 1'b0;
        i_mem_data = 32'h0;
    endtask

    // Wait for a held instruction, stall wait_c cycles, then accept it.
    task automatic accept(input int wait_c);
        int n = 0;
        while (!o_instr_valid && n < 20) begin step(); n++; end
        chk("valid_seen", {31'd0, o_instr_valid}, 32'd1);
        repeat (wait_c) step();
        i_instr_ready = 1'b1;
        step();
        i_instr_ready = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!o_mem_start && n < 20) begin step(); n++; end
        chk("mem_start_seen", {31'd0, o_mem_start}, 32'd1);
    endtask

    // Model update on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_quiet <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_pc    <= 24'h0;
            m_fetch <= 24'h0;
        end else if (i_pc_load) begin
            m_quiet <= 1'b1;
            m_valid <= 1'b0;
            m_fetch <= {i_pc_load_addr[23:2], 2'b00};
        end else if (m_quiet) begin
            m_quiet <= 1'b0;
        end else if (!m_valid) begin
            if (i_mem_done) begin
                m_valid <= 1'b1;
                m_data  <= word_le(m_fetch);
                m_pc    <= m_fetch;
            end
        end else if (i_instr_ready) begin
            m_valid <= 1'b0;
            m_fetch <= m_pc + 24'd4;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_valid", {31'd0, o_instr_valid}, {31'd0, m_valid});
            chk("mem_start", {31'd0, o_mem_start}, {31'd0, (!m_valid && !m_quiet)});
            if (!m_valid && !m_quiet) chk("mem_addr", {8'd0, o_mem_addr}, {8'd0, m_fetch});
            if (m_valid) begin
                chk("instr_data", o_instr_data, m_data);
                chk("instr_pc", {8'd0, o_instr_pc}, {8'd0, m_pc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_tab[4];
        int rdy_tab[4];
        lat_tab = '{0, 1, 3, 2};
        rdy_tab = '{0, 2, 1, 4};

        rst_n = 1'b0;
        i_pc_load = 1'b0;
        i_pc_load_addr = 24'h0;
        i_instr_ready = 1'b0;
        i_mem_done = 1'b0;
        i_mem_data = 32'h0;

        // Reset values while held in reset.
        step(); step();
        chk_en = 1'b1;
        step();
        chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_start", {31'd0, o_mem_start}, 32'd0);
        chk("rst_data", o_instr_data, 32'h0);
        chk("rst_pc", {8'd0, o_instr_pc}, 32'h0);

        // First fetch after release: one idle cycle, then address 0.
        rst_n = 1'b1;
        step();
        chk("first_start", {31'd0, o_mem_start}, 32'd1);
        chk("first_addr", {8'd0, o_mem_addr}, 32'h0);
        i_mem_done = 1'b1;
        i_mem_data = 32'h13000000;
        step();
        i_mem_done = 1'b0;
        i_mem_data = 32'h0;
        chk("first_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("first_data", o_instr_data, 32'h00000013);
        chk("first_pc", {8'd0, o_instr_pc}, 32'h0);
        chk("start_low_after_done", {31'd0, o_mem_start}, 32'd0);

        // Consumer stalls 10 cycles; then accept and expect address 4.
        repeat (10) step();
        i_instr_ready = 1'b1;
        step();
        i_instr_ready = 1'b0;
        chk("seq_start", {31'd0, o_mem_start}, 32'd1);
        chk("seq_addr", {8'd0, o_mem_addr}, 32'h000004);
        chk("seq_valid_drop", {31'd0, o_instr_valid}, 32'd0);
        serve(2);
        chk("word4_data", o_instr_data, 32'h5B5A5958);
        chk("word4_pc", {8'd0, o_instr_pc}, 32'h000004);

        // mem_done while holding an instruction is ignored.
        i_mem_done = 1'b1;
        i_mem_data = 32'hCAFEF00D;
        step();
        i_mem_done = 1'b0;
        i_mem_data = 32'h0;
        step();
        chk("hold_ignore_data", o_instr_data, 32'h5B5A5958);
        accept(1);

        // Sequential fetches with varied read latency and consumer stalls.
        for (int i = 0; i < 4; i++) begin
            serve(lat_tab[i]);
            accept(rdy_tab[i]);
        end

        // Wrap: redirect to 0xFFFFFF (low bits dropped), accept, expect 0.
        wait_start();
        i_pc_load = 1'b1;
        i_pc_load_addr = 24'hFFFFFF;
        step();
        i_pc_load = 1'b0;
        serve(0);
        chk("wrap_pc", {8'd0, o_instr_pc}, 32'hFFFFFC);
        accept(0);
        chk("wrap_addr", {8'd0, o_mem_addr}, 32'h000000);
        chk("wrap_start", {31'd0, o_mem_start}, 32'd1);
        serve(1);
        chk("wrap_data", o_instr_data, 32'h00000013);
        accept(0);

        // Redirect during a request; a late completion is discarded.
        wait_start();
        i_pc_load = 1'b1;
        i_pc_load_addr = 24'h001237;
        step();
        i_pc_load = 1'b0;
        chk("redir_gap", {31'd0, o_mem_start}, 32'd0);
        i_mem_done = 1'b1;
        i_mem_data = 32'hDEADBEEF;
        step();
        i_mem_done = 1'b0;
        i_mem_data = 32'h0;
        chk("redir_start", {31'd0, o_mem_start}, 32'd1);
        chk("redir_addr", {8'd0, o_mem_addr}, 32'h001234);
        chk("redir_no_valid", {31'd0, o_instr_valid}, 32'd0);
        serve(1);
        chk("redir_pc", {8'd0, o_instr_pc}, 32'h001234);

        // Redirect and handshake in the same cycle: redirect target wins.
        i_pc_load = 1'b1;
        i_pc_load_addr = 24'h000200;
        i_instr_ready = 1'b1;
        step();
        i_pc_load = 1'b0;
        i_instr_ready = 1'b0;
        chk("both_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("both_gap", {31'd0, o_mem_start}, 32'd0);
        step();
        chk("both_addr", {8'd0, o_mem_addr}, 32'h000200);
        serve(0);
        accept(2);

        // Redirect in the same cycle as a completion: completion dropped.
        wait_start();
        i_pc_load = 1'b1;
        i_pc_load_addr = 24'h000040;
        i_mem_done = 1'b1;
        i_mem_data = word_spi(o_mem_addr);
        step();
        i_pc_load = 1'b0;
        i_mem_done = 1'b0;
        i_mem_data = 32'h0;
        chk("ld_done_valid", {31'd0, o_instr_valid}, 32'd0);
        step();
        chk("ld_done_addr", {8'd0, o_mem_addr}, 32'h000040);
        serve(1);
        accept(0);

        // Reset during a request drops it and discards the completion.
        wait_start();
        rst_n = 1'b0;
        i_mem_done = 1'b1;
        i_mem_data = word_spi(o_mem_addr);
        step();
        rst_n = 1'b1;
        i_mem_done = 1'b0;
        i_mem_data = 32'h0;
        chk("rst_mid_start", {31'd0, o_mem_start}, 32'd0);
        chk("rst_mid_valid", {31'd0, o_instr_valid}, 32'd0);
        step();
        chk("rst_mid_addr", {8'd0, o_mem_addr}, 32'h000000);
        serve(0);
        chk("rst_mid_data", o_instr_data, 32'h00000013);
        accept(0);
        step(); step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
